// File: rtl/regfile_wr_scoreboard.sv
// Write side of the 8x16 register file: decoded write port, two bypassed read
// ports, flat register image and a pending-write scoreboard that stalls decode.
module regfile_wr_scoreboard #(
  parameter int NREG = 8,
  parameter int DW   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [2:0]         wr_addr,
  input  logic [DW-1:0]      wr_data,
  input  logic               rsv_en,
  input  logic [2:0]         rsv_addr,
  input  logic [2:0]         rd0_addr,
  input  logic               rd0_use,
  output logic [DW-1:0]      rd0_data,
  input  logic [2:0]         rd1_addr,
  input  logic               rd1_use,
  output logic [DW-1:0]      rd1_data,
  output logic               stall,
  output logic [NREG-1:0]    pending,
  output logic [NREG*DW-1:0] regs_flat
);

  logic [DW-1:0]   regs [NREG];
  logic [NREG-1:0] pend;
  logic [NREG-1:0] wr_dec;
  logic [NREG-1:0] rsv_dec;
  logic            byp0;
  logic            byp1;
  logic            hazard0;
  logic            hazard1;

  assign wr_dec  = wr_en  ? (NREG'(1) << wr_addr)  : '0;
  assign rsv_dec = rsv_en ? (NREG'(1) << rsv_addr) : '0;

  // Clear-then-set: a reservation in the same cycle as the write to that
  // register belongs to a younger instruction and must survive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      pend <= '0;
    end else begin
      if (wr_en) regs[wr_addr] <= wr_data;
      pend <= (pend & ~wr_dec) | rsv_dec;
    end
  end

  assign byp0 = wr_en && (wr_addr == rd0_addr);
  assign byp1 = wr_en && (wr_addr == rd1_addr);

  assign rd0_data = byp0 ? wr_data : regs[rd0_addr];
  assign rd1_data = byp1 ? wr_data : regs[rd1_addr];

  assign hazard0 = rd0_use && pend[rd0_addr] && !byp0;
  assign hazard1 = rd1_use && pend[rd1_addr] && !byp1;
  assign stall   = hazard0 || hazard1;

  assign pending = pend;

  for (genvar g = 0; g < NREG; g++) begin : g_flat
    assign regs_flat[g*DW +: DW] = regs[g];
  end

endmodule

// File: tb/tb_regfile_wr_scoreboard.sv
// Bench for regfile_wr_scoreboard: directed scenarios plus random traffic,
// all checked against an array-based model of the register file.
module tb_regfile_wr_scoreboard;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wr_en;
  logic [2:0]   wr_addr;
  logic [15:0]  wr_data;
  logic         rsv_en;
  logic [2:0]   rsv_addr;
  logic [2:0]   rd0_addr;
  logic         rd0_use;
  logic [15:0]  rd0_data;
  logic [2:0]   rd1_addr;
  logic         rd1_use;
  logic [15:0]  rd1_data;
  logic         stall;
  logic [7:0]   pending;
  logic [127:0] regs_flat;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_regs [8];
  logic [7:0]  m_pend;

  regfile_wr_scoreboard #(.NREG(8), .DW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rd0_addr(rd0_addr), .rd0_use(rd0_use), .rd0_data(rd0_data),
    .rd1_addr(rd1_addr), .rd1_use(rd1_use), .rd1_data(rd1_data),
    .stall(stall), .pending(pending), .regs_flat(regs_flat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] m_flat();
    logic [127:0] f = '0;
    for (int i = 0; i < 8; i++) f[i*16 +: 16] = m_regs[i];
    return f;
  endfunction

  function automatic logic [15:0] m_rd(input logic [2:0] a);
    return (wr_en && wr_addr == a) ? wr_data : m_regs[a];
  endfunction

  function automatic logic m_stall();
    logic h0, h1;
    h0 = rd0_use && m_pend[rd0_addr] && !(wr_en && wr_addr == rd0_addr);
    h1 = rd1_use && m_pend[rd1_addr] && !(wr_en && wr_addr == rd1_addr);
    return h0 || h1;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_pend = '0;
  endtask

  task automatic drive(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                       input logic re, input logic [2:0] ra,
                       input logic [2:0] a0, input logic u0,
                       input logic [2:0] a1, input logic u1);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rsv_en = re; rsv_addr = ra;
    rd0_addr = a0; rd0_use = u0; rd1_addr = a1; rd1_use = u1;
    #1;
    chk("rd0", 128'(rd0_data), 128'(m_rd(rd0_addr)));
    chk("rd1", 128'(rd1_data), 128'(m_rd(rd1_addr)));
    chk("stall", 128'(stall), 128'(m_stall()));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) begin
      if (wr_en) begin
        m_regs[wr_addr] = wr_data;
        m_pend[wr_addr] = 1'b0;
      end
      if (rsv_en) m_pend[rsv_addr] = 1'b1;
    end
    #1;
    chk("flat", regs_flat, m_flat());
    chk("pending", 128'(pending), 128'(m_pend));
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en = 0; wr_addr = 0; wr_data = 0; rsv_en = 0; rsv_addr = 0;
    rd0_addr = 0; rd0_use = 0; rd1_addr = 0; rd1_use = 0;
    m_clear();
    #12;
    chk("rst_flat", regs_flat, 128'h0);
    chk("rst_pend", 128'(pending), 128'h0);
    chk("rst_stall", 128'(stall), 128'h0);
    rst_n = 1'b1;

    // Reset mid-operation, then write after release
    drive(1, 3, 16'hBEEF, 1, 2, 0, 0, 0, 0);
    step();
    chk("t1_beef", 128'(regs_flat[63:48]), 128'h BEEF);
    #1 rst_n = 1'b0;
    #1;
    m_clear();
    chk("t1_async_flat", regs_flat, 128'h0);
    chk("t1_async_pend", 128'(pending), 128'h0);
    drive(1, 3, 16'h55AA, 1, 3, 3, 1, 4, 1);
    chk("t1_rst_byp", 128'(rd0_data), 128'h55AA);
    chk("t1_rst_rd1", 128'(rd1_data), 128'h0);
    step();
    rst_n = 1'b1;
    drive(1, 5, 16'h1234, 0, 0, 0, 0, 0, 0);
    step();
    chk("t1_w5", regs_flat, 128'h1234 << 80);

    // Bypass on both ports
    drive(1, 2, 16'hA5A5, 0, 0, 2, 1, 2, 1);
    chk("t2_byp0", 128'(rd0_data), 128'hA5A5);
    chk("t2_byp1", 128'(rd1_data), 128'hA5A5);
    step();
    drive(0, 0, 16'h0, 0, 0, 2, 1, 2, 1);
    chk("t2_rd0", 128'(rd0_data), 128'hA5A5);
    chk("t2_rd1", 128'(rd1_data), 128'hA5A5);

    // Load hazard on reg4
    drive(0, 0, 16'h0, 1, 4, 0, 0, 0, 0);
    step();
    for (int c = 0; c < 3; c++) begin
      drive(0, 0, 16'h0, 0, 0, 0, 0, 4, 1);
      chk("t3_stall", 128'(stall), 128'h1);
      step();
    end
    drive(1, 4, 16'h0042, 0, 0, 0, 0, 4, 1);
    chk("t3_unstall", 128'(stall), 128'h0);
    chk("t3_rd1", 128'(rd1_data), 128'h0042);
    step();
    chk("t3_pend4", 128'(pending[4]), 128'h0);

    // Unused operand never stalls
    drive(0, 0, 16'h0, 1, 6, 0, 0, 0, 0);
    step();
    drive(0, 0, 16'h0, 0, 0, 6, 0, 6, 0);
    chk("t4_nouse", 128'(stall), 128'h0);
    drive(0, 0, 16'h0, 0, 0, 6, 1, 0, 0);
    chk("t4_use", 128'(stall), 128'h1);

    // Reserve/write collisions
    drive(1, 1, 16'h7777, 1, 1, 0, 0, 0, 0);
    step();
    chk("t5_reg1", 128'(regs_flat[31:16]), 128'h7777);
    chk("t5_pend1", 128'(pending[1]), 128'h1);
    drive(0, 0, 16'h0, 1, 7, 0, 0, 0, 0);
    step();
    drive(1, 7, 16'h0101, 1, 1, 0, 0, 0, 0);
    step();
    chk("t5_pend1b", 128'(pending[1]), 128'h1);
    chk("t5_pend7", 128'(pending[7]), 128'h0);

    // All-register sweep
    for (int n = 0; n < 8; n++) begin
      drive(1, 3'(n), 16'(16'h1111 * n), 0, 0, 0, 0, 0, 0);
      step();
    end
    for (int n = 0; n < 8; n++) begin
      drive(0, 0, 16'h0, 0, 0, 3'(n), 0, 3'(7 - n), 0);
      chk("t6_rd0", 128'(rd0_data), 128'(16'(16'h1111 * n)));
      chk("t6_rd1", 128'(rd1_data), 128'(16'(16'h1111 * (7 - n))));
    end
    chk("t6_flat", regs_flat,
        128'h7777_6666_5555_4444_3333_2222_1111_0000);

    // Random traffic; decode never reserves while stalled
    for (int c = 0; c < 400; c++) begin
      wr_en = 1'($urandom_range(0, 1)); wr_addr = 3'($urandom);
      wr_data = 16'($urandom);
      rd0_addr = 3'($urandom); rd0_use = 1'($urandom);
      rd1_addr = 3'($urandom); rd1_use = 1'($urandom);
      rsv_en = 1'b0; rsv_addr = 3'($urandom);
      if (!m_stall()) rsv_en = ($urandom_range(0, 2) == 0);
      drive(wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
            rd0_addr, rd0_use, rd1_addr, rd1_use);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wr_scoreboard.md
Name: regfile_wr_scoreboard

Overview:
- Write side of the 16-bit datapath register file: eight 16-bit general registers.
- Provides:
  - a decoded write port (3-bit address into one of 8 destinations);
  - two bypassed read ports;
  - a flat 128-bit register image that feeds the existing 8:1 16-bit read muxes;
  - a pending-write scoreboard that stalls decode on read-after-write hazards for multi-cycle producers (loads).
- Sits between writeback (write port) and decode (read ports, reservations, stall).

Parameters:
- NREG, 8, number of registers; fixed at 8 (3-bit addressing).
- DW, 16, register data width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- wr_en  input  1  write strobe from writeback.
- wr_addr  input  3  destination register of write.
- wr_data  input  16  write data.
- rsv_en  input  1  reserve strobe from decode; marks destination as pending.
- rsv_addr  input  3  register to reserve.
- rd0_addr  input  3  read port 0 address.
- rd0_use  input  1  read port 0 operand actually needed this cycle.
- rd0_data  output  16  read port 0 data (bypassed).
- rd1_addr  input  3  read port 1 address.
- rd1_use  input  1  read port 1 operand actually needed this cycle.
- rd1_data  output  16  read port 1 data (bypassed).
- stall  output  1  hazard; decode must hold its instruction.
- pending  output  8  scoreboard bit per register.
- regs_flat  output  128  register image; reg n at bits [16n+15:16n].

Behaviour:
- Reset:
  - rst_n low asynchronously clears all 8 registers to 16'h0000 and pending to 8'h00, regardless of clk.
  - While reset is held: regs_flat = 0, pending = 0, stall = 0, and rd0_data/rd1_data show only the bypass value (wr_data if wr_en and address matches, else 0).
  - Reset asserted mid-operation discards all reservations; no write completes in that cycle.
- Write:
  - On a rising edge with wr_en=1, reg[wr_addr] <= wr_data.
  - Exactly one register is written; the other seven hold.
  - Write latency is 1 cycle; regs_flat reflects the new value after the edge.
- Write clears reservation: a rising edge with wr_en=1 clears pending[wr_addr].
- Reserve: a rising edge with rsv_en=1 sets pending[rsv_addr].
- Reserve and write to the same address in the same cycle: set wins. pending stays 1, the data is still written, and the new reservation belongs to the younger instruction.
- Reserve and write to different addresses: both take effect.
- Reserving an already-pending register: no error; the bit stays 1.
- Read ports, combinational, identical rules for ports 0 and 1:
  - rdN_data = wr_data if wr_en=1 and wr_addr==rdN_addr;
  - otherwise rdN_data = reg[rdN_addr].
  - Both ports may address the same register; both return the same value.
- Stall, combinational:
  - stall = hazard0 OR hazard1, where
  - hazardN = rdN_use AND pending[rdN_addr] AND NOT (wr_en AND wr_addr==rdN_addr).
  - The bypass resolves a hazard in the cycle the write arrives.
  - rdN_use=0 never stalls.
- rsv_en is not gated by stall inside this block; decode must not assert rsv_en while stall=1.
- regs_flat and pending are registered state only; no bypass is applied to them.
- All register indices 0..7 are general purpose; no register is hardwired.

Test Plan:
1. Reset, write check: assert rst_n=0 mid-cycle after writing reg3=16'hBEEF -> regs_flat=0 and pending=0 immediately, with no clk edge. Release reset, then write reg5=16'h1234 -> regs_flat[95:80]=16'h1234; all other slices remain 0.
2. Bypass: wr_en=1, wr_addr=2, wr_data=16'hA5A5, rd0_addr=2, rd1_addr=2 in the same cycle -> rd0_data=rd1_data=16'hA5A5 before the edge; after the edge with wr_en=0, both still read 16'hA5A5.
3. Load hazard:
   - rsv_en on reg4, then next cycle rd1_addr=4 with rd1_use=1 -> stall=1 for 3 cycles.
   - On the cycle wr_en=1, wr_addr=4, wr_data=16'h0042 -> stall=0 and rd1_data=16'h0042.
   - pending[4]=0 after the edge.
4. Unused operand: pending[6]=1, rd0_addr=6, rd0_use=0 -> stall=0.
5. Collision: rsv_en and wr_en both to reg1 with wr_data=16'h7777 -> after the edge, reg1=16'h7777 and pending[1]=1. Later rsv_en reg1 plus wr_en reg7 -> pending[1]=1, pending[7]=0.
6. All-register sweep: write reg n = 16'h1111*n for n=0..7 on consecutive cycles, then read all via rd0/rd1 -> each matches and regs_flat = {16'h7777,...,16'h0000}.
